// File: rtl/phase_timer_if.sv
// phase_timer_if: strobes and preset into the phase timer, countdown status out
interface phase_timer_if #(parameter int WIDTH = 6);
    logic             tick;
    logic             load;
    logic [WIDTH-1:0] preset;
    logic             hold;
    logic [WIDTH-1:0] count;
    logic [2:0]       tens;
    logic [3:0]       units;
    logic             busy;
    logic             paused;
    logic             expired;
    modport master (output tick, load, preset, hold,
                    input  count, tens, units, busy, paused, expired);
    modport slave  (input  tick, load, preset, hold,
                    output count, tens, units, busy, paused, expired);
endinterface

// File: rtl/phase_timer.sv
// phase_timer: loads a phase duration, counts it down on a 1 Hz tick, pulses expired at zero
module phase_timer #(
    parameter int WIDTH   = 6,
    parameter int MAX_VAL = 59
) (
    input logic         clk,
    input logic         rst,
    phase_timer_if.slave p
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
    state_t           state, state_n;
    logic [WIDTH-1:0] count_q, count_n, r;
    logic [2:0]       tens_q, t;
    logic [3:0]       units_q;
    logic             exp_q, exp_n;
    always_comb begin
        state_n = state;
        count_n = count_q;
        exp_n   = 1'b0;
        if (p.load) begin
            if (p.preset != '0) begin
                count_n = p.preset > WIDTH'(MAX_VAL) ? WIDTH'(MAX_VAL) : p.preset;
                state_n = p.hold ? PAUSE : RUN;
            end else begin
                count_n = '0;
                exp_n   = 1'b1;
                state_n = IDLE;
            end
        end else if (state == RUN) begin
            if (p.hold)
                state_n = PAUSE;
            else if (p.tick && count_q > WIDTH'(1))
                count_n = count_q - WIDTH'(1);
            else if (p.tick) begin
                count_n = '0;
                exp_n   = 1'b1;
                state_n = IDLE;
            end
        end else if (state == PAUSE && !p.hold)
            state_n = RUN;
    end
    // digits come from the next count so they line up with count on the same edge
    always_comb begin
        r = count_n;
        t = '0;
        for (int i = 0; i < 5; i++)
            if (r >= WIDTH'(10)) begin
                r = r - WIDTH'(10);
                t = t + 3'd1;
            end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count_q <= '0;
            tens_q  <= '0;
            units_q <= '0;
            exp_q   <= 1'b0;
        end else begin
            state   <= state_n;
            count_q <= count_n;
            tens_q  <= t;
            units_q <= r[3:0];
            exp_q   <= exp_n;
        end
    end
    assign p.count   = count_q;
    assign p.tens    = tens_q;
    assign p.units   = units_q;
    assign p.busy    = state != IDLE;
    assign p.paused  = state == PAUSE;
    assign p.expired = exp_q;
endmodule

// File: tb/tb_phase_timer.sv
// tb_phase_timer: directed plan plus random traffic, checked every cycle against a seconds-level model
module tb_phase_timer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;
    int m_count = 0;
    bit m_act = 1'b0, m_pause = 1'b0, m_exp = 1'b0;
    phase_timer_if #(.WIDTH(6)) ifc();
    phase_timer #(.WIDTH(6), .MAX_VAL(59)) dut (.clk(clk), .rst(rst), .p(ifc));
    always #5 clk = ~clk;
    // model: remaining seconds plus running/frozen flags
    always @(posedge clk) begin
        if (rst) begin
            m_count = 0; m_act = 0; m_pause = 0; m_exp = 0;
        end else begin
            m_exp = 0;
            if (ifc.load) begin
                if (ifc.preset == 0) begin
                    m_count = 0; m_exp = 1; m_act = 0; m_pause = 0;
                end else begin
                    m_count = ifc.preset > 59 ? 59 : int'(ifc.preset);
                    m_act = 1; m_pause = ifc.hold;
                end
            end else if (m_act && !m_pause) begin
                if (ifc.hold) m_pause = 1;
                else if (ifc.tick) begin
                    m_count = m_count - 1;
                    if (m_count == 0) begin m_exp = 1; m_act = 0; end
                end
            end else if (m_act && !ifc.hold)
                m_pause = 0;
        end
    end
    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    always @(negedge clk) if (checking) begin
        chk("count", int'(ifc.count), m_count);
        chk("tens", int'(ifc.tens), m_count / 10);
        chk("units", int'(ifc.units), m_count % 10);
        chk("busy", int'(ifc.busy), int'(m_act));
        chk("paused", int'(ifc.paused), int'(m_act && m_pause));
        chk("expired", int'(ifc.expired), int'(m_exp));
    end
    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask
    task automatic do_load(input int v);
        ifc.preset = 6'(v); ifc.load = 1; step(); ifc.load = 0;
    endtask
    task automatic do_tick();
        ifc.tick = 1; step(); ifc.tick = 0;
    endtask
    initial begin
        ifc.tick = 0; ifc.load = 0; ifc.preset = 0; ifc.hold = 0;
        step(2);
        rst = 0;
        checking = 1;
        chk("reset count", int'(ifc.count), 0);
        chk("reset busy", int'(ifc.busy), 0);
        chk("reset expired", int'(ifc.expired), 0);
        do_load(5);
        chk("load5 count", int'(ifc.count), 5);
        chk("load5 units", int'(ifc.units), 5);
        chk("load5 busy", int'(ifc.busy), 1);
        for (int i = 1; i <= 5; i++) begin
            do_tick();
            chk("t5 count", int'(ifc.count), 5 - i);
            chk("t5 expired", int'(ifc.expired), i == 5 ? 1 : 0);
            chk("t5 busy", int'(ifc.busy), i == 5 ? 0 : 1);
            step(9);
        end
        chk("t5 expired low", int'(ifc.expired), 0);
        do_load(22);
        repeat (3) begin do_tick(); step(2); end
        chk("22-3 count", int'(ifc.count), 19);
        chk("22-3 tens", int'(ifc.tens), 1);
        chk("22-3 units", int'(ifc.units), 9);
        ifc.tick = 1; do_load(30); ifc.tick = 0;
        chk("load+tick count", int'(ifc.count), 30);
        chk("load+tick expired", int'(ifc.expired), 0);
        do_load(15);
        repeat (4) begin do_tick(); step(); end
        ifc.hold = 1;
        for (int i = 0; i < 50; i++) begin
            ifc.tick = (i % 10 == 0);
            step();
        end
        ifc.tick = 0;
        chk("hold count", int'(ifc.count), 11);
        chk("hold paused", int'(ifc.paused), 1);
        ifc.hold = 0; step();
        for (int i = 1; i <= 11; i++) begin
            do_tick();
            chk("post-hold expired", int'(ifc.expired), i == 11 ? 1 : 0);
            step();
        end
        do_load(63);
        chk("sat count", int'(ifc.count), 59);
        chk("sat tens", int'(ifc.tens), 5);
        chk("sat units", int'(ifc.units), 9);
        do_load(0);
        chk("zero expired", int'(ifc.expired), 1);
        chk("zero busy", int'(ifc.busy), 0);
        step();
        do_load(30);
        repeat (10) begin do_tick(); step(); end
        chk("pre-rst count", int'(ifc.count), 20);
        rst = 1; step(); rst = 0;
        chk("rst count", int'(ifc.count), 0);
        chk("rst busy", int'(ifc.busy), 0);
        chk("rst expired", int'(ifc.expired), 0);
        repeat (3) begin do_tick(); step(); end
        chk("idle ticks count", int'(ifc.count), 0);
        do_load(30);
        repeat (18) begin do_tick(); step(); end
        chk("mid count", int'(ifc.count), 12);
        do_load(5);
        chk("reload count", int'(ifc.count), 5);
        chk("reload busy", int'(ifc.busy), 1);
        for (int i = 1; i <= 5; i++) begin
            do_tick();
            chk("reload expired", int'(ifc.expired), i == 5 ? 1 : 0);
            step();
        end
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom % 400) == 0;
            ifc.load = ($urandom % 30) == 0;
            ifc.preset = 6'($urandom_range(0, 63));
            ifc.tick = ($urandom % 6) == 0;
            if (($urandom % 25) == 0) ifc.hold = !ifc.hold;
            step();
        end
        rst = 0; ifc.load = 0; ifc.tick = 0; ifc.hold = 0;
        step(2);
        checking = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/phase_timer.md
# phase_timer

Down-counting phase timer for the traffic-light controller, directly downstream of the preset generator. Loads the 6-bit duration (seconds) that generator produces for the current light phase and counts it down on a 1 Hz tick. Raises a one-cycle `expired` pulse that the phase FSM uses to advance state. Also provides BCD tens/units of the remaining time for the 7-segment display driver.

## Interface
- `WIDTH`, 6: counter/preset width in bits.
- `MAX_VAL`, 59: saturation limit applied to loaded presets (display is two digits).
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tick`  in  1  one-cycle 1 Hz enable strobe.
- `load`  in  1  one-cycle strobe; samples `preset` (driven by the preset generator's `pulse`).
- `preset`  in  WIDTH  duration in seconds (5, 15, 22, 30 in normal use).
- `hold`  in  1  level; freezes countdown while high (pedestrian/maintenance hold).
- `count`  out  WIDTH  remaining seconds, registered.
- `tens`  out  3  BCD tens digit of `count`, registered.
- `units`  out  4  BCD units digit of `count`, registered.
- `busy`  out  1  high in RUN or PAUSE.
- `paused`  out  1  high in PAUSE.
- `expired`  out  1  one-cycle pulse when countdown reaches 0.

## Operation
- FSM states: IDLE, RUN, PAUSE.
- Reset (`rst`=1, overrides all inputs, any state): state IDLE; `count`=0, `tens`=0, `units`=0, `busy`=0, `paused`=0, `expired`=0.
- Load, evaluated in every state and winning over `tick` and `hold` in the same cycle:
  - `load`=1, `preset`≠0: `count` ← min(`preset`, MAX_VAL); go to RUN (or PAUSE if `hold`=1).
  - `load`=1, `preset`=0: `count` ← 0, `expired` ← 1, go to IDLE.
  - Reload while RUN/PAUSE restarts the countdown. No `expired` is issued for the aborted interval.
- RUN:
  - `hold`=1 → PAUSE, count frozen; a `tick` in that cycle is ignored.
  - `tick`=1 and `count`>1: `count` ← `count`−1.
  - `tick`=1 and `count`=1: `count` ← 0, `expired` ← 1, go to IDLE.
- PAUSE:
  - `tick` ignored.
  - `hold`=0 → RUN; ticks are counted again from the following cycle.
- IDLE: `tick` and `hold` ignored; `count` holds its last value (0 after expiry).
- `expired` is high for exactly one cycle per completed interval, else 0.
- BCD digits:
  - `tens`/`units` are registered from the next-state value of `count`, so they always match `count` in the same cycle.
  - tens = count/10, units = count mod 10, valid for 0..59.
  - Implemented by compare/subtract, no divider.
- Arithmetic is unsigned. `count` never wraps below 0.

## Timing
- Load latency: 1 cycle. `count`, digits and `busy` are valid on the edge after `load`.
- Decrement latency: 1 cycle after a `tick` in RUN.
- `expired` asserts on the same edge that `count` becomes 0 and deasserts on the next edge.
- Total interval: N ticks after load for preset N. A `tick` coincident with `load` is not counted.
- `hold` takes effect at the next edge. Entering or leaving PAUSE costs no ticks beyond the one masked on the entry cycle.
- `rst` mid-countdown: all outputs reach their reset values at the next edge, and no `expired` pulse is issued.

## Test plan
- Reset, then `load` with `preset`=5, then 5 ticks spaced 10 cycles apart:
  - `count` 5→4→3→2→1→0; `tens`/`units` 0/5 … 0/0.
  - `expired` high for exactly 1 cycle with the 5th tick; `busy` falls at the same edge.
- `preset`=22 load, then 3 ticks: `count`=19, `tens`=1, `units`=9. `load`+`tick` in the same cycle with `preset`=30: `count`=30, no decrement, `expired` stays 0.
- `preset`=15, 4 ticks, `hold`=1 for 50 cycles with 5 ticks in that window:
  - `count` stays 11 and `paused`=1.
  - Release `hold`, then 11 ticks → `expired` on the 11th.
- `preset`=63 → `count`=59, `tens`=5, `units`=9. `preset`=0 → `expired` the next cycle, `busy`=0.
- `preset`=30, 10 ticks, then `rst` for 1 cycle: all outputs 0 and no `expired`. Following ticks leave `count`=0.
- Reload `preset`=5 mid-count (`count`=12): `count`=5 and `busy` stays 1, with exactly one `expired` after 5 more ticks.
